// File: rtl/tpu_pkg.sv
// Shared constants and FSM state type for the TPU matrix-multiply unit.
package tpu_pkg;

  localparam int TPU_DATA_W = 8;
  localparam int TPU_OUT_W  = 16;
  localparam int TPU_ACC_W  = 17;
  localparam int TPU_DIM    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mmu_state_t;

endpackage

// File: rtl/tpu_pe.sv
// Output-stationary systolic processing element: signed MAC with
// registered east/south operand pass-through.
module tpu_pe
  import tpu_pkg::*;
#(
  parameter int DATA_W = TPU_DATA_W,
  parameter int ACC_W  = TPU_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] a_w,
  input  logic signed [DATA_W-1:0] b_n,
  output logic signed [DATA_W-1:0] a_e,
  output logic signed [DATA_W-1:0] b_s,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]   a_q, a_d;
  logic signed [DATA_W-1:0]   b_q, b_d;

  always_comb begin
    prod  = a_w * b_n;
    acc_d = acc_q +
      {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    a_d   = a_w;
    b_d   = b_n;
    if (clear) begin
      acc_d = '0;
      a_d   = '0;
      b_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign a_e = a_q;
  assign b_s = b_q;
  assign acc = acc_q;

endmodule

// File: rtl/tpu_systolic_mmu.sv
// 2x2 signed systolic matrix multiply with saturated 16-bit results.
// Define TPU_MMU_RELU_EN to clamp negative results to zero.
module tpu_systolic_mmu
  import tpu_pkg::*;
#(
  parameter int DATA_W = TPU_DATA_W,
  parameter int OUT_W  = TPU_OUT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DATA_W-1:0]   a_in,
  input  logic [4*DATA_W-1:0]   b_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*OUT_W-1:0]    c_out
);

  localparam int ACC_W = 2*DATA_W + 1;
  localparam int N     = TPU_DIM;

  mmu_state_t state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [4*DATA_W-1:0] a_q, a_d;
  logic [4*DATA_W-1:0] b_q, b_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [4*OUT_W-1:0] c_q, c_d;
  logic [4*OUT_W-1:0] c_sat;
  logic clear;
  int   step_i;

  logic signed [DATA_W-1:0] feed_a [N];
  logic signed [DATA_W-1:0] feed_b [N];
  logic signed [DATA_W-1:0] pe_a_w [N][N];
  logic signed [DATA_W-1:0] pe_b_n [N][N];
  logic signed [DATA_W-1:0] pe_a_e [N][N];
  logic signed [DATA_W-1:0] pe_b_s [N][N];
  logic signed [ACC_W-1:0]  pe_acc [N][N];

  assign step_i = {30'd0, step_q};

  // Skewed edge feeds: row i / column j lag by i / j steps.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      feed_a[i] = '0;
      feed_b[i] = '0;
      if (state_q == RUN && step_i >= i && step_i - i < N) begin
        feed_a[i] = a_q[DATA_W*(N*i + step_i - i) +: DATA_W];
        feed_b[i] = b_q[DATA_W*(N*(step_i - i) + i) +: DATA_W];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [OUT_W-1:0] sat_v;

      if (j == 0) begin : g_aw
        assign pe_a_w[i][j] = feed_a[i];
      end else begin : g_aw
        assign pe_a_w[i][j] = pe_a_e[i][j-1];
      end

      if (i == 0) begin : g_bn
        assign pe_b_n[i][j] = feed_b[j];
      end else begin : g_bn
        assign pe_b_n[i][j] = pe_b_s[i-1][j];
      end

      tpu_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .a_w  (pe_a_w[i][j]),
        .b_n  (pe_b_n[i][j]),
        .a_e  (pe_a_e[i][j]),
        .b_s  (pe_b_s[i][j]),
        .acc  (pe_acc[i][j])
      );

      // Overflow when the bits above the result sign disagree with it.
      always_comb begin
        sat_v = pe_acc[i][j][OUT_W-1:0];
        if (pe_acc[i][j][ACC_W-1:OUT_W-1] !=
            {(ACC_W-OUT_W+1){pe_acc[i][j][ACC_W-1]}}) begin
          sat_v = pe_acc[i][j][ACC_W-1] ?
                  {1'b1, {(OUT_W-1){1'b0}}} :
                  {1'b0, {(OUT_W-1){1'b1}}};
        end
`ifdef TPU_MMU_RELU_EN
        if (sat_v[OUT_W-1]) sat_v = '0;
`endif
      end

      assign c_sat[OUT_W*(N*i+j) +: OUT_W] = sat_v;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_d     = c_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          clear   = 1'b1;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        c_d     = c_sat;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_q     <= c_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign c_out = c_q;

endmodule

// File: tb/tb_tpu_systolic_mmu.sv
// Self-checking bench for tpu_systolic_mmu: directed table, random
// vectors against a matrix-product model, and multi-cycle sequences.
module tb_tpu_systolic_mmu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [63:0] c_out;

  int checks;
  int failures;

  tpu_systolic_mmu dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a_in (a_in),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .c_out(c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] c;
    string       nm;
  } vec_t;

  vec_t tbl [4];

  function automatic logic [31:0] p8(input int e0, input int e1,
                                     input int e2, input int e3);
    return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  function automatic logic [63:0] p16(input int e0, input int e1,
                                      input int e2, input int e3);
    return {e3[15:0], e2[15:0], e1[15:0], e0[15:0]};
  endfunction

  function automatic logic [63:0] relu16(input logic [63:0] c);
    logic [63:0] r;
    r = c;
`ifdef TPU_MMU_RELU_EN
    for (int k = 0; k < 4; k++)
      if (r[16*k+15]) r[16*k +: 16] = 16'd0;
`endif
    return r;
  endfunction

  // C = A x B with plain integer arithmetic, then clamp (and ReLU).
  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] c;
    int sum;
    c = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        sum = 0;
        for (int k = 0; k < 2; k++)
          sum += $signed(a[8*(2*i+k) +: 8]) * $signed(b[8*(2*k+j) +: 8]);
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
`ifdef TPU_MMU_RELU_EN
        if (sum < 0) sum = 0;
`endif
        c[16*(2*i+j) +: 16] = 16'(sum);
      end
    end
    return c;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse; operands scrambled after capture.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string nm);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    chk1({nm, " busy@E0"}, busy, 1'b1);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk1({nm, " early_done"}, done, 1'b0);
      chk1({nm, " busy_run"}, busy, 1'b1);
    end
    tick();
    chk1({nm, " done@E5"}, done, 1'b1);
    chk1({nm, " busy@E5"}, busy, 1'b0);
    chk64({nm, " c_out"}, c_out, exp);
    tick();
    chk1({nm, " done_pulse"}, done, 1'b0);
  endtask

  logic [31:0] ra, rb, a1, b1, a2, b2;
  logic        exp_done;
  logic        exp_busy;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;

    tbl[0] = '{p8(1, 2, 3, 4), p8(1, 0, 0, 1),
               p16(1, 2, 3, 4), "ident"};
    tbl[1] = '{p8(-1, 2, 3, -4), p8(5, 6, 7, 8),
               p16(9, 10, -13, -14), "signed"};
    tbl[2] = '{p8(-128, -128, -128, -128), p8(-128, -128, -128, -128),
               p16(32767, 32767, 32767, 32767), "sat_pos"};
    tbl[3] = '{p8(-128, -128, -128, -128), p8(127, 127, 127, 127),
               p16(-32512, -32512, -32512, -32512), "sat_neg"};

    tick();
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk64("rst_c", c_out, 64'd0);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 4; t++)
      run_mult(tbl[t].a, tbl[t].b, relu16(tbl[t].c), tbl[t].nm);

    for (int t = 0; t < 8; t++) begin
      ra = $urandom;
      rb = $urandom;
      run_mult(ra, rb, model(ra, rb), "rand");
    end

    // Re-start at E0+2 with new operands must be ignored.
    a1 = p8(1, 2, 3, 4);
    b1 = p8(5, 6, 7, 8);
    a2 = p8(-7, 9, 11, -3);
    b2 = p8(2, -5, 6, 13);
    a_in  = a1;
    b_in  = b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk1("rs_done1", done, 1'b0);
    start = 1'b1;
    a_in  = a2;
    b_in  = b2;
    tick();
    chk1("rs_busy2", busy, 1'b1);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    tick();
    chk1("rs_done3", done, 1'b0);
    tick();
    chk1("rs_done4", done, 1'b0);
    tick();
    chk1("rs_done5", done, 1'b1);
    chk64("rs_c", c_out, model(a1, b1));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("rs_no_extra_done", done, 1'b0);
      chk1("rs_idle_busy", busy, 1'b0);
    end

    // Reset in the middle of a run.
    a_in  = a2;
    b_in  = b2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk64("mid_rst_c", c_out, 64'd0);
    tick();
    chk1("mid_rst_done_hold", done, 1'b0);
    rst = 1'b0;
    tick();
    run_mult(a2, b2, model(a2, b2), "post_rst");

    // Start held high: back-to-back runs every 6 cycles.
    a_in  = p8(-1, 2, 3, -4);
    b_in  = p8(5, 6, 7, 8);
    start = 1'b1;
    for (int n = 0; n <= 17; n++) begin
      tick();
      exp_done = (n == 5) || (n == 11) || (n == 17);
      exp_busy = (n % 6) != 5;
      chk1("held_done", done, exp_done);
      chk1("held_busy", busy, exp_busy);
      if (exp_done)
        chk64("held_c", c_out, relu16(p16(9, 10, -13, -14)));
    end
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    tick();
    chk1("held_stop_done", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
